// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - pattern mode encodings shared by the display test-pattern source
package display_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_COUNT   = 2'd0,
    MODE_STAGGER = 2'd1,
    MODE_WALK    = 2'd2,
    MODE_ALLSAME = 2'd3
  } mode_t;

endpackage

// File: rtl/step_timer.sv
// rtl/step_timer.sv - step strobe source: free-run prescaler or synchronised pushbutton edge
module step_timer #(
  parameter int PRESCALE = 2500000
) (
  input  logic clk5,
  input  logic reset,
  input  logic run,
  input  logic stepBtn,
  input  logic clear,
  output logic step
);

  localparam int PW = $clog2(PRESCALE);
  localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pcount;
  logic btnMeta;
  logic btnSync;
  logic btnPrev;
  logic autoStep;
  logic manualStep;

  assign autoStep   = run && (pcount == PLAST);
  assign manualStep = !run && btnSync && !btnPrev;
  assign step       = autoStep || manualStep;

  // Button flops reset high so a button held through reset needs release then press.
  always_ff @(posedge clk5) begin
    if (reset) begin
      pcount  <= '0;
      btnMeta <= 1'b1;
      btnSync <= 1'b1;
      btnPrev <= 1'b1;
    end else begin
      btnMeta <= stepBtn;
      btnSync <= btnMeta;
      btnPrev <= btnSync;
      if (clear || !run || autoStep) begin
        pcount <= '0;
      end else begin
        pcount <= pcount + PW'(1);
      end
    end
  end

endmodule

// File: rtl/display_pattern_gen.sv
// rtl/display_pattern_gen.sv - NDIGITS hex test-pattern source for the seven-segment display
module display_pattern_gen
  import display_pkg::*;
#(
  parameter int NDIGITS  = 4,
  parameter int PRESCALE = 2500000
) (
  input  logic                   clk5,
  input  logic                   reset,
  input  logic [1:0]             mode,
  input  logic                   run,
  input  logic                   stepBtn,
  output logic [4*NDIGITS-1:0]   dispVal,
  output logic [NDIGITS-1:0]     digitEn,
  output logic                   stepPulse
);

  localparam int SW   = 4 * NDIGITS;
  localparam int POSW = $clog2(NDIGITS);
  localparam logic [POSW-1:0] POS_LAST = POSW'(NDIGITS - 1);

  mode_t             modeReg;
  mode_t             modeNext;
  logic [SW-1:0]     s;
  logic [SW-1:0]     sNext;
  logic [POSW-1:0]   pos;
  logic [POSW-1:0]   posNext;
  logic [3:0]        sym;
  logic [3:0]        symNext;
  logic              modeChange;
  logic              step;
  logic              pulseNext;
  logic [SW-1:0]     valNext;
  logic [NDIGITS-1:0] enNext;

  assign modeChange = (mode_t'(mode) != modeReg);

  step_timer #(
    .PRESCALE(PRESCALE)
  ) u_timer (
    .clk5    (clk5),
    .reset   (reset),
    .run     (run),
    .stepBtn (stepBtn),
    .clear   (modeChange),
    .step    (step)
  );

  // A mode change wins over a coincident step, which is dropped.
  always_comb begin
    modeNext  = modeReg;
    sNext     = s;
    posNext   = pos;
    symNext   = sym;
    pulseNext = 1'b0;
    if (modeChange) begin
      modeNext = mode_t'(mode);
      sNext    = '0;
      posNext  = '0;
      symNext  = '0;
    end else if (step) begin
      pulseNext = 1'b1;
      sNext     = s + SW'(1);
      if (modeReg == MODE_WALK && pos != POS_LAST) begin
        posNext = pos + POSW'(1);
      end else begin
        symNext = sym + 4'd1;
        if (modeReg == MODE_WALK) begin
          posNext = '0;
        end
      end
    end
  end

  always_comb begin
    valNext = '0;
    enNext  = '1;
    for (int k = 0; k < NDIGITS; k++) begin
      case (modeNext)
        MODE_COUNT:   valNext[4*k +: 4] = sNext[4*k +: 4];
        MODE_STAGGER: valNext[4*k +: 4] = sNext[k +: 4];
        MODE_WALK: begin
          valNext[4*k +: 4] = (posNext == POSW'(k)) ? symNext : 4'd0;
          enNext[k]         = (posNext == POSW'(k));
        end
        default:      valNext[4*k +: 4] = symNext;
      endcase
    end
  end

  always_ff @(posedge clk5) begin
    if (reset) begin
      modeReg   <= mode_t'(mode);
      s         <= '0;
      pos       <= '0;
      sym       <= '0;
      dispVal   <= '0;
      digitEn   <= '1;
      stepPulse <= 1'b0;
    end else begin
      modeReg   <= modeNext;
      s         <= sNext;
      pos       <= posNext;
      sym       <= symNext;
      dispVal   <= valNext;
      digitEn   <= enNext;
      stepPulse <= pulseNext;
    end
  end

endmodule
